gpio_command_queue: RTL and testbench

Command buffer directly upstream of the GPIO controller. Accepts IO commands from the core's IO issue port, queues them, and presents them one at a time on the controller's request interface. Captures the controller's same-cycle response into a registered writeback slot with valid/ready back-pressure, so the core never stalls on the controller.

---
 rtl/gpio_command_queue_pkg.sv | 32 +++
 rtl/gpio_command_queue_if.sv | 45 ++++
 rtl/gpio_command_queue_fifo.sv | 56 +++++
 rtl/gpio_command_queue.sv | 125 ++++++++++++
 tb/tb_gpio_command_queue.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_command_queue_pkg.sv
`default_nettype none
// =====================================================================
// gpio_pkg : shared types and constants for the GPIO command queue
// Rev 1.0
// =====================================================================
package gpio_pkg;

   localparam int CMD_DATA_W = 16;
   localparam int CMD_REG_W  = 4;

   // Command word layout: [15:13] IOAddr, [12:10] Command, [9:0] payload
   localparam int IOADDR_MSB  = 15;
   localparam int IOADDR_LSB  = 13;
   localparam int COMMAND_MSB = 12;
   localparam int COMMAND_LSB = 10;

   localparam int CMDQ_TIMEOUT_CYCLES = 255;

   typedef struct packed {
      logic                  resp_req;
      logic [CMD_REG_W-1:0]  dest_reg;
      logic [CMD_DATA_W-1:0] data;
   } io_cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } cmdq_state_t;

endpackage
`default_nettype wire

// File: rtl/gpio_command_queue_if.sv
`default_nettype none
// =====================================================================
// gpio_cmdq_if : core command, controller request and writeback channels
// Rev 1.0
// =====================================================================
interface gpio_cmdq_if #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_WIDTH  = 4
);
   logic                  CmdValid;
   logic                  CmdReady;
   logic                  CmdResponseRequested;
   logic [REG_WIDTH-1:0]  CmdDestReg;
   logic [DATA_WIDTH-1:0] CmdData;

   logic                  IO_REQ;
   logic                  IO_CommandEn;
   logic                  IO_ResponseRequested;
   logic [REG_WIDTH-1:0]  IO_DestReg;
   logic [DATA_WIDTH-1:0] IO_Data;
   logic                  IO_ACK;
   logic                  IO_RegResponseFlag;
   logic [REG_WIDTH-1:0]  IO_DestRegRet;
   logic [DATA_WIDTH-1:0] IO_DataRet;

   logic                  RspValid;
   logic                  RspReady;
   logic [REG_WIDTH-1:0]  RspDestReg;
   logic [DATA_WIDTH-1:0] RspData;

   modport master (
      output CmdValid, CmdResponseRequested, CmdDestReg, CmdData,
      output IO_ACK, IO_RegResponseFlag, IO_DestRegRet, IO_DataRet, RspReady,
      input  CmdReady, IO_REQ, IO_CommandEn, IO_ResponseRequested, IO_DestReg, IO_Data,
      input  RspValid, RspDestReg, RspData
   );

   modport slave (
      input  CmdValid, CmdResponseRequested, CmdDestReg, CmdData,
      input  IO_ACK, IO_RegResponseFlag, IO_DestRegRet, IO_DataRet, RspReady,
      output CmdReady, IO_REQ, IO_CommandEn, IO_ResponseRequested, IO_DestReg, IO_Data,
      output RspValid, RspDestReg, RspData
   );
endinterface
`default_nettype wire

// File: rtl/gpio_command_queue_fifo.sv
`default_nettype none
// =====================================================================
// gpio_cmd_fifo : DEPTH-entry circular buffer of io_cmd_t
// Rev 1.0
// =====================================================================
module gpio_cmd_fifo
   import gpio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   async_rst,
   input  logic                   push_i,
   input  io_cmd_t                wdata_i,
   input  logic                   pop_i,
   output io_cmd_t                head_o,
   output io_cmd_t                second_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   io_cmd_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   rd_nxt;
   logic [AW:0]     count_q;

   // Caller guarantees push only when not full and pop only when not empty
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) rd_ptr_q <= rd_nxt;
         if (push_i && !pop_i)      count_q <= count_q + 1'b1;
         else if (pop_i && !push_i) count_q <= count_q - 1'b1;
      end
   end

   assign rd_nxt   = rd_ptr_q + 1'b1;
   assign head_o   = mem_q[rd_ptr_q];
   assign second_o = mem_q[rd_nxt];
   assign full_o   = (count_q == FULL_CNT);
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
endmodule
`default_nettype wire

// File: rtl/gpio_command_queue.sv
`default_nettype none
// =====================================================================
// gpio_command_queue : command FIFO, issue FSM and writeback slot ahead
// of the GPIO controller. Optional timeout: GPIO_CMDQ_TIMEOUT_EN. Rev 1.0
// =====================================================================
module gpio_command_queue
   import gpio_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 16,
   parameter int REG_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   async_rst,
   input  logic                   clk_en,
   gpio_cmdq_if.slave             io,
   output logic [$clog2(DEPTH):0] QueueCount,
   output logic                   TimeoutFlag
);
   localparam int CW = $clog2(DEPTH) + 1;

   io_cmd_t               wr_cmd, head, second, nxt_head;
   logic                  full, empty;
   logic [CW-1:0]         count;
   cmdq_state_t           state_q;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [REG_WIDTH-1:0]  rsp_dest_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  push, complete, tmo_fire, pop, capture;
   logic                  nonempty_nxt, stall_nxt;

   assign wr_cmd.resp_req = io.CmdResponseRequested;
   assign wr_cmd.dest_reg = CMD_REG_W'(io.CmdDestReg);
   assign wr_cmd.data     = CMD_DATA_W'(io.CmdData);

   assign push     = io.CmdValid && !full && clk_en;
   assign complete = (state_q == ISSUE) && io.IO_ACK && clk_en;
   assign pop      = complete || tmo_fire;
   assign capture  = complete && io.IO_RegResponseFlag;

   assign rsp_valid_d = capture || (rsp_valid_q && !(io.RspReady && clk_en));

   gpio_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .async_rst(async_rst),
      .push_i   (push),
      .wdata_i  (wr_cmd),
      .pop_i    (pop),
      .head_o   (head),
      .second_o (second),
      .full_o   (full),
      .empty_o  (empty),
      .count_o  (count)
   );

   // Head as it will be after this edge, so the stall decision is made a cycle early
   always_comb begin
      nxt_head = head;
      if (pop)        nxt_head = (count > CW'(1)) ? second : wr_cmd;
      else if (empty) nxt_head = wr_cmd;
   end

   assign nonempty_nxt = pop ? ((count > CW'(1)) || push) : (!empty || push);
   assign stall_nxt    = nxt_head.resp_req && rsp_valid_d;

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= IDLE;
      end else if (clk_en && ((state_q != ISSUE) || pop)) begin
         if (!nonempty_nxt)  state_q <= IDLE;
         else if (stall_nxt) state_q <= STALL;
         else                state_q <= ISSUE;
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         rsp_valid_q <= 1'b0;
         rsp_dest_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (capture) begin
            rsp_dest_q <= io.IO_DestRegRet;
            rsp_data_q <= io.IO_DataRet;
         end
      end
   end

`ifdef GPIO_CMDQ_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;
   logic       tmo_flag_q;

   assign tmo_fire = (state_q == ISSUE) && !io.IO_ACK && clk_en &&
                     (tmo_cnt_q == 8'(CMDQ_TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
      end else if (clk_en) begin
         if ((state_q == ISSUE) && !io.IO_ACK && !tmo_fire) tmo_cnt_q <= tmo_cnt_q + 8'd1;
         else                                               tmo_cnt_q <= '0;
         if (tmo_fire) tmo_flag_q <= 1'b1;
      end
   end

   assign TimeoutFlag = tmo_flag_q;
`else
   assign tmo_fire    = 1'b0;
   assign TimeoutFlag = 1'b0;
`endif

   assign io.CmdReady             = !full;
   assign io.IO_REQ               = (state_q == ISSUE);
   assign io.IO_CommandEn         = (state_q == ISSUE);
   assign io.IO_ResponseRequested = head.resp_req;
   assign io.IO_DestReg           = REG_WIDTH'(head.dest_reg);
   assign io.IO_Data              = DATA_WIDTH'(head.data);
   assign io.RspValid             = rsp_valid_q;
   assign io.RspDestReg           = rsp_dest_q;
   assign io.RspData              = rsp_data_q;
   assign QueueCount              = count;
endmodule
`default_nettype wire

// File: tb/tb_gpio_command_queue.sv
`default_nettype none
// =====================================================================
// tb_gpio_command_queue : directed self-checking bench for gpio_command_queue
// Rev 1.0
// =====================================================================
module tb_gpio_command_queue;
   logic       clk = 1'b0;
   logic       async_rst;
   logic       clk_en;
   logic [2:0] QueueCount;
   logic       TimeoutFlag;
   int         checks = 0;
   int         errors = 0;

   gpio_cmdq_if #(.DATA_WIDTH(16), .REG_WIDTH(4)) bus ();

   gpio_command_queue #(.DEPTH(4), .DATA_WIDTH(16), .REG_WIDTH(4)) dut (
      .clk        (clk),
      .async_rst  (async_rst),
      .clk_en     (clk_en),
      .io         (bus),
      .QueueCount (QueueCount),
      .TimeoutFlag(TimeoutFlag)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_CmdReady"},   bus.CmdReady, 1);
      chk({pfx, "_IO_REQ"},     bus.IO_REQ, 0);
      chk({pfx, "_IO_CmdEn"},   bus.IO_CommandEn, 0);
      chk({pfx, "_IO_RespReq"}, bus.IO_ResponseRequested, 0);
      chk({pfx, "_IO_Dest"},    bus.IO_DestReg, 0);
      chk({pfx, "_IO_Data"},    bus.IO_Data, 0);
      chk({pfx, "_RspValid"},   bus.RspValid, 0);
      chk({pfx, "_RspDest"},    bus.RspDestReg, 0);
      chk({pfx, "_RspData"},    bus.RspData, 0);
      chk({pfx, "_Count"},      QueueCount, 0);
      chk({pfx, "_Timeout"},    TimeoutFlag, 0);
   endtask

   initial begin
      async_rst                = 1'b1;
      clk_en                   = 1'b1;
      bus.CmdValid             = 1'b0;
      bus.CmdResponseRequested = 1'b0;
      bus.CmdDestReg           = '0;
      bus.CmdData              = '0;
      bus.IO_ACK               = 1'b0;
      bus.IO_RegResponseFlag   = 1'b0;
      bus.IO_DestRegRet        = '0;
      bus.IO_DataRet           = '0;
      bus.RspReady             = 1'b0;
      repeat (2) step();
      async_rst = 1'b0;
      chk_reset_values("reset");

      // Write-only command: one request cycle, no writeback
      bus.CmdValid = 1'b1; bus.CmdData = 16'h0401; bus.IO_ACK = 1'b1;
      step();
      bus.CmdValid = 1'b0;
      chk("t1_req_high", bus.IO_REQ, 1);
      chk("t1_cmden",    bus.IO_CommandEn, 1);
      chk("t1_data",     bus.IO_Data, 16'h0401);
      chk("t1_count1",   QueueCount, 1);
      step();
      chk("t1_req_low",  bus.IO_REQ, 0);
      chk("t1_count0",   QueueCount, 0);
      chk("t1_rspvalid", bus.RspValid, 0);

      // Read command: response captured into the slot
      bus.CmdValid = 1'b1; bus.CmdResponseRequested = 1'b1;
      bus.CmdDestReg = 4'h3; bus.CmdData = 16'h2000;
      bus.IO_RegResponseFlag = 1'b1; bus.IO_DestRegRet = 4'h3; bus.IO_DataRet = 16'h00A5;
      step();
      bus.CmdValid = 1'b0;
      chk("t2_req",      bus.IO_REQ, 1);
      chk("t2_respreq",  bus.IO_ResponseRequested, 1);
      chk("t2_dest",     bus.IO_DestReg, 3);
      chk("t2_rsp_pre",  bus.RspValid, 0);
      step();
      chk("t2_rspvalid", bus.RspValid, 1);
      chk("t2_rspdest",  bus.RspDestReg, 3);
      chk("t2_rspdata",  bus.RspData, 16'h00A5);
      chk("t2_req_low",  bus.IO_REQ, 0);

      // Two reads with a blocked writeback port
      bus.RspReady = 1'b1;
      step();
      bus.RspReady = 1'b0;
      chk("t3_drained", bus.RspValid, 0);
      bus.CmdValid = 1'b1; bus.CmdDestReg = 4'h5; bus.CmdData = 16'h2001;
      bus.IO_DestRegRet = 4'h5; bus.IO_DataRet = 16'h00A1;
      step();
      chk("t3_a_req",  bus.IO_REQ, 1);
      chk("t3_a_dest", bus.IO_DestReg, 5);
      bus.CmdDestReg = 4'h6; bus.CmdData = 16'h2002;
      step();
      bus.CmdValid = 1'b0;
      chk("t3_a_rspvalid", bus.RspValid, 1);
      chk("t3_a_rspdata",  bus.RspData, 16'h00A1);
      chk("t3_b_stall",    bus.IO_REQ, 0);
      chk("t3_b_count",    QueueCount, 1);
      chk("t3_b_head",     bus.IO_DestReg, 6);
      step();
      chk("t3_b_stall2",   bus.IO_REQ, 0);
      chk("t3_slot_hold",  bus.RspData, 16'h00A1);
      bus.RspReady = 1'b1; bus.IO_DestRegRet = 4'h6; bus.IO_DataRet = 16'h00B2;
      step();
      bus.RspReady = 1'b0;
      chk("t3_b_issue",    bus.IO_REQ, 1);
      chk("t3_b_dest",     bus.IO_DestReg, 6);
      step();
      chk("t3_b_rspvalid", bus.RspValid, 1);
      chk("t3_b_rspdest",  bus.RspDestReg, 6);
      chk("t3_b_rspdata",  bus.RspData, 16'h00B2);
      chk("t3_b_req_low",  bus.IO_REQ, 0);
      chk("t3_count0",     QueueCount, 0);
      bus.RspReady = 1'b1; bus.IO_RegResponseFlag = 1'b0;
      step();
      bus.RspReady = 1'b0;
      chk("t3_final_drain", bus.RspValid, 0);

      // Fill the FIFO with the controller not acking
      bus.IO_ACK = 1'b0; bus.CmdResponseRequested = 1'b0; bus.CmdDestReg = '0;
      for (int i = 0; i < 5; i++) begin
         bus.CmdValid = 1'b1;
         bus.CmdData  = 16'(16'h1000 + i);
         chk("t4_ready", bus.CmdReady, (i < 4) ? 1 : 0);
         step();
      end
      bus.CmdValid = 1'b0;
      chk("t4_count4", QueueCount, 4);
      chk("t4_full",   bus.CmdReady, 0);
      chk("t4_req",    bus.IO_REQ, 1);
      chk("t4_head",   bus.IO_Data, 16'h1000);

      // Clock enable low freezes everything
      bus.IO_ACK = 1'b1; clk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_count_hold", QueueCount, 4);
         chk("t5_req_hold",   bus.IO_REQ, 1);
         chk("t5_head_hold",  bus.IO_Data, 16'h1000);
      end
      clk_en = 1'b1;
      step();
      chk("t5_count3", QueueCount, 3);
      chk("t5_head1",  bus.IO_Data, 16'h1001);
      chk("t5_ready",  bus.CmdReady, 1);
      step();
      chk("t5_head2",  bus.IO_Data, 16'h1002);
      step();
      chk("t5_head3",  bus.IO_Data, 16'h1003);
      step();
      chk("t5_empty",  QueueCount, 0);
      chk("t5_idle",   bus.IO_REQ, 0);

      // Fill slot, then a write-only command must still issue
      bus.CmdValid = 1'b1; bus.CmdResponseRequested = 1'b1; bus.CmdDestReg = 4'h9;
      bus.CmdData = 16'h2003; bus.IO_RegResponseFlag = 1'b1;
      bus.IO_DestRegRet = 4'h9; bus.IO_DataRet = 16'h5A5A;
      step();
      bus.CmdValid = 1'b0;
      step();
      bus.IO_RegResponseFlag = 1'b0;
      chk("t6_slot_full", bus.RspValid, 1);
      chk("t6_slot_data", bus.RspData, 16'h5A5A);
      bus.IO_ACK = 1'b0; bus.CmdValid = 1'b1; bus.CmdResponseRequested = 1'b0;
      bus.CmdDestReg = '0; bus.CmdData = 16'h6123;
      step();
      bus.CmdValid = 1'b0;
      chk("t6_wr_issue", bus.IO_REQ, 1);
      chk("t6_wr_data",  bus.IO_Data, 16'h6123);

`ifdef GPIO_CMDQ_TIMEOUT_EN
      repeat (254) step();
      chk("t7_still_waiting", bus.IO_REQ, 1);
      chk("t7_flag_pre",      TimeoutFlag, 0);
      step();
      chk("t7_dropped",       bus.IO_REQ, 0);
      chk("t7_count0",        QueueCount, 0);
      chk("t7_flag_set",      TimeoutFlag, 1);
      chk("t7_no_capture",    bus.RspData, 16'h5A5A);
      repeat (5) step();
      chk("t7_flag_sticky",   TimeoutFlag, 1);
      bus.CmdValid = 1'b1; bus.CmdData = 16'h6124;
      step();
      bus.CmdValid = 1'b0;
      chk("t7_reissue",       bus.IO_REQ, 1);
`else
      repeat (300) step();
      chk("t7_waits",     bus.IO_REQ, 1);
      chk("t7_count1",    QueueCount, 1);
      chk("t7_flag_tied", TimeoutFlag, 0);
`endif

      // Asynchronous reset in the middle of an issue
      #2 async_rst = 1'b1;
      #1;
      chk_reset_values("midrst");
      step();
      async_rst = 1'b0;
      step();
      chk("midrst_discard", bus.IO_REQ, 0);
      chk("midrst_count",   QueueCount, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
